// File: rtl/screen_pkg.sv
// Shared definitions for the screen RAM producer, the RAM itself and the VGA reader.
package screen_pkg;
  localparam int SCR_ADDR_W = 11;
  localparam int SCR_DATA_W = 8;
  localparam int SCR_DEPTH  = 2048;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_FILL    = 2'b01,
    OP_CLEAR   = 2'b10,
    OP_PATTERN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/screen_draw_writer_if.sv
// Command handshake, RAM write port and status of the screen draw writer.
interface screen_draw_if #(
  parameter int ADDR_W = screen_pkg::SCR_ADDR_W,
  parameter int DATA_W = screen_pkg::SCR_DATA_W
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/screen_wr_addr_gen.sv
// Wrapping write-address counter and remaining-word counter for one burst.
module screen_wr_addr_gen #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = ADDR_W'(32'(start_i) % DEPTH);
      cnt_d  = count_i;
    end else if (step_i) begin
      addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == (ADDR_W+1)'(1));
endmodule

// File: rtl/screen_draw_writer.sv
// Turns WRITE/FILL/CLEAR/PATTERN commands into bursts of single-cycle screen RAM writes.
// SCREEN_WR_PATTERN_EN enables the incrementing PATTERN op; otherwise PATTERN only pulses done.
import screen_pkg::*;

module screen_draw_writer #(
  parameter int                ADDR_W    = SCR_ADDR_W,
  parameter int                DATA_W    = SCR_DATA_W,
  parameter int                DEPTH     = SCR_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  screen_draw_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  op_e               op;
  logic [ADDR_W:0]   len_sat, eff_cnt;
  logic [ADDR_W-1:0] start_addr;
  logic              load, step, last;
  logic              pat_q, pat_d;
  logic              wr_en_q, done_q;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  assign op      = op_e'(bus.cmd_op);
  assign len_sat = (bus.cmd_len > DEPTH_CNT) ? DEPTH_CNT : bus.cmd_len;

  always_comb begin
    eff_cnt    = '0;
    start_addr = bus.cmd_addr;
    case (op)
      OP_WRITE: eff_cnt = (ADDR_W+1)'(1);
      OP_FILL:  eff_cnt = len_sat;
      OP_CLEAR: begin
        eff_cnt    = DEPTH_CNT;
        start_addr = '0;
      end
      OP_PATTERN: begin
`ifdef SCREEN_WR_PATTERN_EN
        eff_cnt = len_sat;
`else
        eff_cnt = '0;
`endif
      end
      default: eff_cnt = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    pat_d     = pat_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: if (bus.cmd_valid) begin
        load      = 1'b1;
        pat_d     = (op == OP_PATTERN);
        wr_data_d = (op == OP_CLEAR) ? CLEAR_VAL : bus.cmd_data;
        state_d   = (eff_cnt == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
        else begin
          step = 1'b1;
          if (pat_q) wr_data_d = wr_data_q + DATA_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pat_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      wr_en_q   <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      wr_data_q <= wr_data_d;
    end
  end

  screen_wr_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (step),
    .start_i (start_addr),
    .count_i (eff_cnt),
    .addr_o  (bus.wr_addr),
    .last_o  (last)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_screen_draw_writer.sv
// Directed bench for screen_draw_writer with a write-list model and per-cycle write checker.
module tb_screen_draw_writer;
  import screen_pkg::*;

  localparam int DEPTH = SCR_DEPTH;
`ifdef SCREEN_WR_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_draw_if #(.ADDR_W(SCR_ADDR_W), .DATA_W(SCR_DATA_W)) bus ();
  screen_draw_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];
  wr_t cap_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt(op_e op, int len);
    int sat;
    sat = (len > DEPTH) ? DEPTH : len;
    case (op)
      OP_WRITE: return 1;
      OP_FILL:  return sat;
      OP_CLEAR: return DEPTH;
      default:  return PAT_EN ? sat : 0;
    endcase
  endfunction

  // Expected write list: consecutive addresses mod DEPTH from the start.
  task automatic push_model(op_e op, int addr, int len, int data, output int n);
    int s;
    wr_t w;
    n = model_cnt(op, len);
    s = (op == OP_CLEAR) ? 0 : addr % DEPTH;
    for (int i = 0; i < n; i++) begin
      w.a = (s + i) % DEPTH;
      if (op == OP_CLEAR)        w.d = 0;
      else if (op == OP_PATTERN) w.d = (data + i) % 256;
      else                       w.d = data;
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    wr_t c;
    if (rst_n) begin
      chk("ready_vs_busy", int'(bus.cmd_ready), int'(!bus.busy));
      if (bus.wr_en) begin
        c.a = int'(bus.wr_addr);
        c.d = int'(bus.wr_data);
        cap_q.push_back(c);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got addr 0x%0h data 0x%0h want no write", c.a, c.d);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", c.a, e.a);
          chk("wr_data", c.d, e.d);
        end
      end
    end
  end

  task automatic start_cmd(op_e op, int addr, int len, int data, bit hold,
                           output time acc_t, output int n);
    int t;
    cap_q.delete();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_addr  = 11'(addr);
    bus.cmd_len   = 12'(len);
    bus.cmd_data  = 8'(data);
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) chk("accept_timeout", 0, 1);
    push_model(op, addr, len, data, n);
    @(posedge clk);
    acc_t = $time;
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int n);
    int busy_c;
    int done_c;
    @(negedge clk);
    chk("first_wr_en", int'(bus.wr_en), int'(n > 0));
    busy_c = 0;
    done_c = 0;
    for (int t = 0; t < DEPTH + 16 && bus.busy; t++) begin
      busy_c++;
      if (bus.done) done_c++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_c, n + 1);
    chk("done_pulses", done_c, 1);
    chk("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2;
    int n, n2, ncap;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_cmd(OP_WRITE, 'h123, 0, 'hA5, 1'b0, t1, n);
    wait_done(n);
    chk("write_count", cap_q.size(), 1);
    if (cap_q.size() == 1) begin
      chk("write_addr_lit", cap_q[0].a, 'h123);
      chk("write_data_lit", cap_q[0].d, 'hA5);
    end

    start_cmd(OP_FILL, 2046, 4, 'h3C, 1'b0, t1, n);
    wait_done(n);
    chk("fill_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("fill_a0_lit", cap_q[0].a, 2046);
      chk("fill_a1_lit", cap_q[1].a, 2047);
      chk("fill_a2_lit", cap_q[2].a, 0);
      chk("fill_a3_lit", cap_q[3].a, 1);
      chk("fill_d3_lit", cap_q[3].d, 'h3C);
    end

    start_cmd(OP_CLEAR, 500, 0, 'h5A, 1'b0, t1, n);
    wait_done(n);
    chk("clear_count", cap_q.size(), 2048);
    if (cap_q.size() == 2048) begin
      chk("clear_first_lit", cap_q[0].a, 0);
      chk("clear_last_lit", cap_q[2047].a, 2047);
      chk("clear_data_lit", cap_q[1000].d, 0);
    end

    start_cmd(OP_FILL, 5, 0, 'h11, 1'b0, t1, n);
    wait_done(n);
    chk("fill0_count", cap_q.size(), 0);

    start_cmd(OP_FILL, 10, 4095, 'hC3, 1'b0, t1, n);
    wait_done(n);
    chk("fill_sat_count", cap_q.size(), 2048);

    // Back-to-back: valid stays high, fields churn while busy.
    start_cmd(OP_FILL, 'h40, 3, 'h55, 1'b1, t1, n);
    bus.cmd_op   = 2'(OP_WRITE);
    bus.cmd_addr = 11'h080;
    bus.cmd_data = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      bus.cmd_data = 8'($urandom);
    end
    bus.cmd_data = 8'h99;
    push_model(OP_WRITE, 'h80, 0, 'h99, n2);
    @(posedge clk);
    t2 = $time;
    #1 bus.cmd_valid = 1'b0;
    chk("accept_spacing", int'(t2 - t1), (n + 2) * 10);
    wait_done(n2);
    chk("b2b_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("b2b_first_data_lit", cap_q[0].d, 'h55);
      chk("b2b_second_addr_lit", cap_q[3].a, 'h80);
      chk("b2b_second_data_lit", cap_q[3].d, 'h99);
    end

    start_cmd(OP_PATTERN, 0, 3, 'hFE, 1'b0, t1, n);
    wait_done(n);
`ifdef SCREEN_WR_PATTERN_EN
    chk("pat_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("pat_d0_lit", cap_q[0].d, 'hFE);
      chk("pat_d1_lit", cap_q[1].d, 'hFF);
      chk("pat_d2_lit", cap_q[2].d, 'h00);
      chk("pat_a2_lit", cap_q[2].a, 2);
    end
`else
    chk("pat_count", cap_q.size(), 0);
`endif

    // Reset in the middle of a 100-word fill.
    start_cmd(OP_FILL, 'h200, 100, 'h77, 1'b0, t1, n);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_busy", int'(bus.busy), 0);
    exp_q.delete();
    ncap = cap_q.size();
    chk("abort_writes", ncap, 10);
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_wr_en", int'(bus.wr_en), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_abort_wr_en", int'(bus.wr_en), 0);
      chk("post_abort_ready", int'(bus.cmd_ready), 1);
    end
    chk("post_abort_writes", cap_q.size(), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
